// File: rtl/playfield_line_clear.sv
// -----------------------------------------------------------------------------
// playfield_line_clear
//
// Multi-cycle line-clear engine for a Tetris playfield. When start arrives it
// takes a snapshot of the settled field. It then scans that snapshot one row
// per cycle, from the bottom row (ROWS-1) up to the top row (0). Full rows are
// dropped and the remaining rows are compacted toward the bottom, keeping
// their order. The vacated top rows are zero-filled. Results appear with a
// one-cycle done pulse, exactly ROWS+1 edges after the accepting edge.
//
// Optional build macro:
//   PLAYFIELD_SCORE_TABLE_EN - when defined, score_plus uses the weighted table
//                              0,1,3,5,8,... (8+2*(n-4) for n>=5, saturating
//                              at 255). When undefined, score_plus equals
//                              lines_cleared.
//
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset (aborts any operation)
//   start         in   one-cycle request, accepted only while idle
//   field_in      in   settled field, row r = bits [r*COLS +: COLS]
//   total_clr     in   synchronous clear of total_lines
//   busy          out  operation in progress
//   done          out  one-cycle pulse, results valid
//   field_out     out  compacted field, held until the next done
//   lines_cleared out  full rows removed by the last operation
//   score_plus    out  score increment of the last operation
//   total_lines   out  saturating running sum of lines_cleared
// -----------------------------------------------------------------------------
module playfield_line_clear #(
    parameter int ROWS  = 20,
    parameter int COLS  = 20,
    parameter int CNT_W = 5,
    parameter int TOT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ROWS*COLS-1:0] field_in,
    input  logic                 total_clr,
    output logic                 busy,
    output logic                 done,
    output logic [ROWS*COLS-1:0] field_out,
    output logic [CNT_W-1:0]     lines_cleared,
    output logic [7:0]           score_plus,
    output logic [TOT_W-1:0]     total_lines
);

    localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_FILL,
        S_DONE
    } state_t;

    state_t                     r_state;
    state_t                     w_next;

    // Packed [row][col] layout matches the flat port layout bit for bit.
    logic [ROWS-1:0][COLS-1:0]  r_work;       // snapshot, read-only during SCAN
    logic [ROWS-1:0][COLS-1:0]  r_dest;       // compaction target
    logic [ROWS-1:0][COLS-1:0]  w_filled;     // dest with vacated rows zeroed
    logic [IDX_W-1:0]           r_rd;
    logic [IDX_W-1:0]           r_wr;
    logic [CNT_W-1:0]           r_cnt;

    logic [ROWS*COLS-1:0]       r_field_out;
    logic [CNT_W-1:0]           r_lines;
    logic [7:0]                 r_score;
    logic [TOT_W-1:0]           r_total;

    logic                       w_row_full;
    logic [TOT_W-1:0]           w_tot_base;
    logic [TOT_W:0]             w_tot_sum;
    logic [TOT_W-1:0]           w_tot_next;

    // -------------------------------------------------------------------------
    // Score increment for n cleared lines
    // -------------------------------------------------------------------------
    function automatic logic [7:0] f_score(input logic [CNT_W-1:0] n);
`ifdef PLAYFIELD_SCORE_TABLE_EN
        int v;
        case (int'(n))
            0:       v = 0;
            1:       v = 1;
            2:       v = 3;
            3:       v = 5;
            default: v = 8 + 2 * (int'(n) - 4);
        endcase
        if (v > 255) v = 255;
        return 8'(v);
`else
        return 8'(n);
`endif
    endfunction

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block ordering.
            r_state <= w_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: default first, so no path leaves w_next unassigned (no latch).
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_SCAN;
            S_SCAN:  if (r_rd == '0) w_next = S_FILL;   // row 0 processed this edge
            S_FILL:  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;                   // start ignored here
            default: w_next = S_IDLE;
        endcase
    end

    assign busy = (r_state == S_SCAN) || (r_state == S_FILL);
    assign done = (r_state == S_DONE);

    // -------------------------------------------------------------------------
    // Scan datapath
    // -------------------------------------------------------------------------
    assign w_row_full = &r_work[r_rd];

    // Writes go to rows ROWS-1 down to cnt. That leaves rows 0..cnt-1
    // (i.e. 0..wr) unwritten, and they are exactly the ones to zero.
    always_comb begin
        w_filled = r_dest;
        for (int r = 0; r < ROWS; r++) begin
            if (r < int'(r_cnt)) w_filled[r] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the row arrays are plain flops, not RAM, so they are
            // reset along with everything else and an abort leaves no stale data.
            r_work      <= '0;
            r_dest      <= '0;
            r_rd        <= '0;
            r_wr        <= '0;
            r_cnt       <= '0;
            r_field_out <= '0;
            r_lines     <= '0;
            r_score     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_work <= field_in;
                        r_rd   <= IDX_W'(ROWS - 1);
                        r_wr   <= IDX_W'(ROWS - 1);
                        r_cnt  <= '0;
                    end
                end
                S_SCAN: begin
                    if (w_row_full) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end else begin
                        r_dest[r_wr] <= r_work[r_rd];
                        r_wr         <= r_wr - IDX_W'(1);
                    end
                    r_rd <= r_rd - IDX_W'(1);
                end
                S_FILL: begin
                    r_field_out <= w_filled;
                    r_lines     <= r_cnt;
                    r_score     <= f_score(r_cnt);
                end
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Running line total: a clear on the FILL edge takes effect before the add
    // -------------------------------------------------------------------------
    assign w_tot_base = total_clr ? '0 : r_total;
    assign w_tot_sum  = {1'b0, w_tot_base} + (TOT_W + 1)'(r_cnt);
    assign w_tot_next = w_tot_sum[TOT_W] ? '1 : w_tot_sum[TOT_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_total <= '0;
        end else if (r_state == S_FILL) begin
            r_total <= w_tot_next;
        end else if (total_clr) begin
            r_total <= '0;
        end
    end

    assign field_out     = r_field_out;
    assign lines_cleared = r_lines;
    assign score_plus    = r_score;
    assign total_lines   = r_total;

endmodule

// File: tb/tb_playfield_line_clear.sv
// -----------------------------------------------------------------------------
// tb_playfield_line_clear
//
// Directed bench for playfield_line_clear at its default geometry (20x20).
// A second instance with TOT_W=5 shares all inputs. Only its total_lines is
// checked, to exercise saturation at 31.
// -----------------------------------------------------------------------------
module tb_playfield_line_clear;

    localparam int ROWS  = 20;
    localparam int COLS  = 20;
    localparam int CNT_W = 5;
    localparam int N     = ROWS * COLS;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [N-1:0]     field_in;
    logic             total_clr;

    logic             busy, done;
    logic [N-1:0]     field_out;
    logic [CNT_W-1:0] lines_cleared;
    logic [7:0]       score_plus;
    logic [15:0]      total_lines;

    logic             s_busy, s_done;
    logic [N-1:0]     s_field_out;
    logic [CNT_W-1:0] s_lines_cleared;
    logic [7:0]       s_score_plus;
    logic [4:0]       s_total_lines;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    playfield_line_clear #(.ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W), .TOT_W(16)) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .field_in      (field_in),
        .total_clr     (total_clr),
        .busy          (busy),
        .done          (done),
        .field_out     (field_out),
        .lines_cleared (lines_cleared),
        .score_plus    (score_plus),
        .total_lines   (total_lines)
    );

    playfield_line_clear #(.ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W), .TOT_W(5)) u_sat (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .field_in      (field_in),
        .total_clr     (total_clr),
        .busy          (s_busy),
        .done          (s_done),
        .field_out     (s_field_out),
        .lines_cleared (s_lines_cleared),
        .score_plus    (s_score_plus),
        .total_lines   (s_total_lines)
    );

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_score(input int n);
`ifdef PLAYFIELD_SCORE_TABLE_EN
        int t[4] = '{0, 1, 3, 5};
        int v;
        if (n < 4) return t[n];
        v = 8 + 2 * (n - 4);
        return (v > 255) ? 255 : v;
`else
        return n;
`endif
    endfunction

    // One full operation. hold: keep start high until done. clr_fill: pulse
    // total_clr on the FILL edge. poke: extra start pulse mid-scan.
    task automatic run_op(input logic [N-1:0] fin, input logic [N-1:0] exp_f,
                          input int exp_cnt, input int exp_tot, input int exp_sat,
                          input bit hold, input bit clr_fill, input bit poke);
        int n;
        field_in = fin;
        start    = 1'b1;
        @(posedge clk); #1;
        check("busy_after_accept", busy, 1);
        if (!hold) start = 1'b0;
        field_in = ~fin;                     // must not affect the result
        n = 0;
        while (!done && n < 40) begin
            if (poke && n == 5) begin field_in = '1; start = 1'b1; end
            if (poke && n == 6) start = 1'b0;
            if (clr_fill && n == ROWS) total_clr = 1'b1;
            @(posedge clk); #1;
            n++;
            total_clr = 1'b0;
        end
        check("latency", n, ROWS + 1);
        check("done_pulse", done, 1);
        check("busy_at_done", busy, 0);
        check("field_out", field_out, exp_f);
        check("lines_cleared", lines_cleared, exp_cnt);
        check("score_plus", score_plus, exp_score(exp_cnt));
        check("total_lines", total_lines, exp_tot);
        check("sat_total_lines", s_total_lines, exp_sat);
        start = 1'b0;
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
        @(posedge clk); #1;
        check("no_requeue", busy, 0);
    endtask

    logic [N-1:0] f, e;
    bit           saw_done;

    initial begin
        rst_n = 1'b0; start = 1'b0; field_in = '0; total_clr = 1'b0;

        // Reset then idle
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_field_out", field_out, '0);
        check("rst_lines", lines_cleared, 0);
        check("rst_score", score_plus, 0);
        check("rst_total", total_lines, 0);
        saw_done = 0;
        repeat (5) begin @(posedge clk); #1; if (done) saw_done = 1; end
        check("no_done_without_start", saw_done, 0);

        // Single full bottom row
        f = '0; f[19*COLS +: COLS] = 20'hFFFFF; f[18*COLS +: COLS] = 20'h00001;
        e = '0; e[19*COLS +: COLS] = 20'h00001;
        run_op(f, e, 1, 1, 1, 0, 0, 0);

        // Split clear, non-adjacent full rows
        f = '0;
        f[19*COLS +: COLS] = 20'hFFFFF; f[18*COLS +: COLS] = 20'hAAAAA;
        f[17*COLS +: COLS] = 20'hFFFFF; f[16*COLS +: COLS] = 20'h55555;
        e = '0; e[19*COLS +: COLS] = 20'hAAAAA; e[18*COLS +: COLS] = 20'h55555;
        run_op(f, e, 2, 3, 3, 0, 0, 0);

        // All full, twice: the TOT_W=5 instance saturates at 31
        run_op('1, '0, 20, 23, 23, 0, 0, 0);
        run_op('1, '0, 20, 43, 31, 0, 0, 0);
        f = '0;
        f[19*COLS +: COLS] = 20'hFFFFF; f[18*COLS +: COLS] = 20'hAAAAA;
        f[17*COLS +: COLS] = 20'hFFFFF; f[16*COLS +: COLS] = 20'h55555;
        e = '0; e[19*COLS +: COLS] = 20'hAAAAA; e[18*COLS +: COLS] = 20'h55555;
        run_op(f, e, 2, 45, 31, 0, 0, 0);

        // start held high for the whole op, total_clr on the FILL edge, 4 lines
        f = '0;
        for (int r = 16; r < 20; r++) f[r*COLS +: COLS] = 20'hFFFFF;
        f[15*COLS +: COLS] = 20'h12345;
        e = '0; e[19*COLS +: COLS] = 20'h12345;
        run_op(f, e, 4, 4, 4, 1, 1, 0);

        // No full rows, extra start pulse mid-scan is ignored
        f = '0;
        for (int r = 0; r < ROWS; r++) f[r*COLS +: COLS] = 20'(r * 20'h0B3C1 + 1) & 20'h7FFFF;
        run_op(f, f, 0, 4, 4, 0, 0, 1);

        // Mid-op reset at SCAN cycle 10
        field_in = '1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_field_out", field_out, '0);
        check("midrst_total", total_lines, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        saw_done = 0;
        repeat (30) begin @(posedge clk); #1; if (done) saw_done = 1; end
        check("midrst_no_done", saw_done, 0);
        f = '0; f[19*COLS +: COLS] = 20'hFFFFF; f[18*COLS +: COLS] = 20'h00001;
        e = '0; e[19*COLS +: COLS] = 20'h00001;
        run_op(f, e, 1, 1, 1, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
